// File: rtl/cpu_defs.sv
// Shared definitions for the instruction-fetch front end: default widths,
// PC step and the fetch FSM state encoding.
package cpu_defs;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned PC_STEP        = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-side request/done port towards mem_ctrl; the fetch unit is the master.
interface ifetch_unit_if
    import cpu_defs::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  if_valid;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_done;
    logic [DATA_WIDTH-1:0] if_data;

    modport master (output if_valid, output if_addr, input if_done, input if_data);
    modport slave  (input if_valid, input if_addr, output if_done, output if_data);
endinterface

// File: rtl/fetch_queue.sv
// In-order {pc, inst} FIFO between fetch and decode. Flush wins over push/pop;
// a pop on an empty queue is ignored. Callers must not push when full.
module fetch_queue #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [AW-1:0]          push_pc,
    input  logic [DW-1:0]          push_inst,
    output logic [AW-1:0]          head_pc,
    output logic [DW-1:0]          head_inst,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [AW-1:0] pc_mem   [DEPTH];
    logic [DW-1:0] inst_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          pop_eff;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign pop_eff = pop && !empty;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so the increments wrap on their own.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + PW'(1);
            if (pop_eff) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop_eff})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_pc   = pc_mem[rd_ptr];
    assign head_inst = inst_mem[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: one outstanding word read to mem_ctrl, results
// buffered in fetch_queue for decode, redirects flush and restart fetch.
//
// state   | meaning
// ST_IDLE | no request outstanding; issue next cycle if queue has room
// ST_WAIT | request outstanding; waiting for if_done
module ifetch_unit
    import cpu_defs::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    ifetch_unit_if.master         mem,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready
);
    localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

    if ((QUEUE_DEPTH < 2) || ((QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("ifetch_unit: QUEUE_DEPTH must be a power of 2 and >= 2");
    end

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  discard_q;
    logic                  issue, push, pop;
    logic                  q_full, q_empty;
    logic [CW-1:0]         q_count;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!redirect_valid && !q_full) state_d = ST_WAIT;
            ST_WAIT: if (mem.if_done)                state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        issue = 1'b0;
        push  = 1'b0;
        case (state_q)
            ST_IDLE: issue = !redirect_valid && !q_full;
            ST_WAIT: push  = mem.if_done && !discard_q && !redirect_valid;
            default: ;
        endcase
    end

    // The queue flush cancels a same-cycle pop, so pop needs no redirect term.
    assign pop        = inst_valid && inst_ready;
    assign inst_valid = !q_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            discard_q    <= 1'b0;
            mem.if_valid <= 1'b0;
            mem.if_addr  <= '0;
        end else begin
            mem.if_valid <= issue;
            if (issue) mem.if_addr <= pc_q;
            if (redirect_valid) pc_q <= redirect_pc;
            else if (push)      pc_q <= mem.if_addr + ADDR_WIDTH'(PC_STEP);
            // A redirect while waiting poisons the in-flight word; done always clears it.
            if (state_q == ST_WAIT) begin
                if (mem.if_done)         discard_q <= 1'b0;
                else if (redirect_valid) discard_q <= 1'b1;
            end
        end
    end

    fetch_queue #(
        .AW    (ADDR_WIDTH),
        .DW    (DATA_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_pc   (mem.if_addr),
        .push_inst (mem.if_data),
        .head_pc   (inst_pc),
        .head_inst (inst),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    a_done_in_wait: assert property (@(posedge clk) disable iff (rst)
        !(mem.if_done && state_q != ST_WAIT));
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        q_count <= CW'(QUEUE_DEPTH));

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: mem_ctrl-like responder, queue-based reference model
// compared every cycle, plus directed scenarios pinned with literal values.
module tb_ifetch_unit;
    import cpu_defs::*;

    localparam int QD = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    ifetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ifetch_unit #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .QUEUE_DEPTH (QD),
        .RESET_PC    (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    bit          rst_req, ready_req, redir_req;
    logic [31:0] redir_pc_req;
    int          lat;
    bit          lat_rand;
    int          cnt;
    logic [31:0] resp_addr;
    bit          redir_on_done;
    logic [31:0] redir_target;

    logic [31:0] reqs[$];
    logic [31:0] acc_pc[$];
    logic [31:0] acc_inst[$];

    bit          s_if_valid, s_inst_valid, s_fired;
    logic [31:0] s_if_addr;

    bit          m_ok, m_busy, m_discard, m_valid;
    logic [31:0] m_pc, m_addr;
    ent_t        m_q[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: one outstanding read, queue of fetched pairs, redirect flushes.
    function automatic void model_step(bit done, logic [31:0] data);
        bit          issue, push, pop;
        logic [31:0] old_pc;
        if (rst_req) begin
            m_ok = 1; m_busy = 0; m_discard = 0; m_valid = 0;
            m_pc = 32'h0; m_addr = 32'h0; m_q.delete();
            return;
        end
        old_pc = m_pc;
        issue = !m_busy && !redirect_valid && (m_q.size() < QD);
        push  = m_busy && done && !m_discard && !redirect_valid;
        pop   = inst_ready && (m_q.size() != 0) && !redirect_valid;
        if (redirect_valid) begin
            m_q.delete();
            m_pc = redirect_pc;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back('{m_addr, data});
                m_pc = m_addr + 32'd4;
            end
        end
        if (m_busy && done)               begin m_busy = 0; m_discard = 0; end
        else if (m_busy && redirect_valid) m_discard = 1;
        if (issue) begin
            m_busy = 1;
            m_addr = old_pc;
        end
        m_valid = issue;
    endfunction

    task automatic step();
        bit          done;
        logic [31:0] data;
        @(negedge clk);
        s_if_valid   = bus.if_valid;
        s_if_addr    = bus.if_addr;
        s_inst_valid = inst_valid;
        if (m_ok) begin
            chk("if_valid", 64'(bus.if_valid), 64'(m_valid));
            chk("if_addr", 64'(bus.if_addr), 64'(m_addr));
            chk("inst_valid", 64'(inst_valid), 64'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                chk("inst_pc", 64'(inst_pc), 64'(m_q[0].pc));
                chk("inst", 64'(inst), 64'(m_q[0].inst));
            end
        end
        done = 0;
        data = '0;
        if (rst_req) cnt = 0;
        else begin
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    done = 1;
                    data = resp_addr ^ 32'hA5A5_0000;
                end
            end
            if (bus.if_valid) begin
                cnt       = lat_rand ? int'($urandom_range(1, 3)) : lat;
                resp_addr = bus.if_addr;
                reqs.push_back(bus.if_addr);
            end
        end
        s_fired = 0;
        if (redir_on_done && done && !rst_req) begin
            redir_req = 1; redir_pc_req = redir_target; ready_req = 1;
            redir_on_done = 0; s_fired = 1;
        end
        rst            = rst_req;
        redirect_valid = redir_req;
        redirect_pc    = redir_pc_req;
        inst_ready     = ready_req;
        bus.if_done    = done;
        bus.if_data    = data;
        if (!rst_req && inst_valid && inst_ready && !redirect_valid) begin
            acc_pc.push_back(inst_pc);
            acc_inst.push_back(inst);
        end
        model_step(done, data);
        redir_req = 0;
    endtask

    task automatic do_reset();
        rst_req = 1; redir_req = 0; redir_on_done = 0;
        repeat (2) step();
        rst_req = 0;
        reqs.delete(); acc_pc.delete(); acc_inst.delete();
    endtask

    task automatic wait_req(logic [31:0] a, int budget, string name);
        bit hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            step();
            if (s_if_valid && s_if_addr == a) hit = 1;
        end
        chk(name, 64'(hit), 64'd1);
    endtask

    initial begin
        int  ai, ri, found8;
        bit  fired;
        rst = 1; redirect_valid = 0; redirect_pc = '0; inst_ready = 0;
        bus.if_done = 0; bus.if_data = '0;
        rst_req = 1; ready_req = 0; redir_req = 0; redir_pc_req = '0;
        lat = 2; lat_rand = 0; cnt = 0; resp_addr = '0;
        redir_on_done = 0; redir_target = '0; m_ok = 0;

        // 1: free-running fetch from reset
        ready_req = 1; do_reset();
        chk("t1_reset_inst_valid", 64'(s_inst_valid), 64'd0);
        repeat (30) step();
        chk("t1_first_req", 64'(reqs[0]), 64'h0);
        chk("t1_pc0", 64'(acc_pc[0]), 64'h0);
        chk("t1_pc1", 64'(acc_pc[1]), 64'h4);
        chk("t1_pc2", 64'(acc_pc[2]), 64'h8);
        chk("t1_inst0", 64'(acc_inst[0]), 64'hA5A5_0000);
        chk("t1_inst1", 64'(acc_inst[1]), 64'hA5A5_0004);
        chk("t1_inst2", 64'(acc_inst[2]), 64'hA5A5_0008);

        // 2: decode stalled, queue fills, single pop frees one slot
        ready_req = 0; do_reset();
        repeat (40) step();
        chk("t2_nreq", 64'(reqs.size()), 64'd4);
        chk("t2_req3", 64'(reqs[3]), 64'hC);
        ready_req = 1; step(); ready_req = 0;
        chk("t2_npop", 64'(acc_pc.size()), 64'd1);
        chk("t2_pop_pc", 64'(acc_pc[0]), 64'h0);
        repeat (20) step();
        chk("t2_nreq_after", 64'(reqs.size()), 64'd5);
        chk("t2_req4", 64'(reqs[4]), 64'h10);

        // 3: redirect while waiting for 0x8
        lat = 2; ready_req = 1; do_reset();
        wait_req(32'h8, 40, "t3_wait8");
        ai = acc_pc.size(); ri = reqs.size();
        redir_req = 1; redir_pc_req = 32'h100;
        step(); step();
        chk("t3_empty", 64'(s_inst_valid), 64'd0);
        repeat (30) step();
        chk("t3_next_req", 64'(reqs[ri]), 64'h100);
        chk("t3_first_pc", 64'(acc_pc[ai]), 64'h100);
        found8 = 0;
        for (int i = ai; i < acc_pc.size(); i++) if (acc_pc[i] == 32'h8) found8++;
        chk("t3_no8", 64'(found8), 64'd0);

        // 4: redirect coinciding with if_done and a pop
        lat = 2; ready_req = 0; do_reset();
        wait_req(32'h8, 40, "t4_wait8");
        redir_on_done = 1; redir_target = 32'h200;
        ai = acc_pc.size(); ri = reqs.size(); fired = 0;
        for (int i = 0; i < 5 && !fired; i++) begin
            step();
            fired = s_fired;
        end
        chk("t4_fired", 64'(fired), 64'd1);
        step();
        chk("t4_count0", 64'(s_inst_valid), 64'd0);
        repeat (20) step();
        chk("t4_next_req", 64'(reqs[ri]), 64'h200);
        chk("t4_first_pc", 64'(acc_pc[ai]), 64'h200);

        // 5: randomized mix, scoreboard across pointer wrap
        lat_rand = 1; do_reset();
        for (int i = 0; i < 600; i++) begin
            ready_req = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 99) < 4) begin
                redir_req = 1;
                redir_pc_req = (i % 3 == 0) ? $urandom() : ($urandom() & 32'h0000_0FFC);
            end
            rst_req = ($urandom_range(0, 299) == 0);
            step();
        end
        rst_req = 0;
        lat_rand = 0;

        // 6: reset mid-WAIT, then PC wrap-around
        lat = 2; ready_req = 1; do_reset();
        wait_req(32'h4, 40, "t6_wait");
        rst_req = 1; step(); rst_req = 0;
        ri = reqs.size();
        step();
        chk("t6_if_valid0", 64'(s_if_valid), 64'd0);
        chk("t6_inst_valid0", 64'(s_inst_valid), 64'd0);
        repeat (10) step();
        chk("t6_first_addr", 64'(reqs[ri]), 64'h0);
        ai = acc_pc.size();
        redir_req = 1; redir_pc_req = 32'hFFFF_FFFC;
        repeat (25) step();
        chk("t6_wrap_pc0", 64'(acc_pc[ai]), 64'hFFFF_FFFC);
        chk("t6_wrap_pc1", 64'(acc_pc[ai+1]), 64'h0);
        chk("t6_wrap_inst1", 64'(acc_inst[ai+1]), 64'hA5A5_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
